// File: rtl/awgn_ctrl.sv
// Burst controller for a Gaussian noise core: seeds and warms the core, then
// streams its samples through a small FIFO, counting samples lost to back-pressure.
module awgn_ctrl #(
  parameter int WARMUP     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [15:0]  burst_len,
  input  logic [191:0] cfg_seed,
  output logic         core_rst_n,
  output logic [191:0] urng_seed,
  input  logic [15:0]  core_sample,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [15:0]  m_data,
  output logic         busy,
  output logic         done,
  output logic [15:0]  drop_cnt
);

  localparam int DATA_W = 16;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int WW     = $clog2(WARMUP + 2) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_WARMUP, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t              state;
  logic [WW-1:0]       wcnt;
  logic [15:0]         len_q;
  logic [15:0]         gen_cnt;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fill;
  logic                pop;
  logic                full;
  logic                push;
  logic                drop;
  logic                last;

  assign m_valid = (fill != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign pop     = m_valid && m_ready;
  assign full    = (fill == CW'(FIFO_DEPTH));
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign push    = (state == S_STREAM) && (!full || pop);
  assign drop    = (state == S_STREAM) && !push;
  assign last    = (len_q != '0) && (({1'b0, gen_cnt} + 17'd1) == {1'b0, len_q});

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= core_sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fill <= fill + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      len_q      <= '0;
      gen_cnt    <= '0;
      drop_cnt   <= '0;
      urng_seed  <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SEED;
            len_q      <= burst_len;
            urng_seed  <= cfg_seed;
            drop_cnt   <= '0;
            gen_cnt    <= '0;
            wcnt       <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_SEED: begin
          if (wcnt == WW'(1)) begin
            state      <= S_WARMUP;
            wcnt       <= '0;
            core_rst_n <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_WARMUP: begin
          if (wcnt == WW'(WARMUP - 1)) begin
            state <= S_STREAM;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_STREAM: begin
          gen_cnt <= gen_cnt + 16'd1;
          if (last || stop) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fill == '0 || (fill == CW'(1) && pop)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/awgn_ctrl.md
AWGN_CTRL -- requirements
Module: awgn_ctrl

Interface
REQ-001 Parameter WARMUP, default 20: cycles the noise core runs after seeding before its output is treated as valid.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two: depth of the output sample FIFO.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle command pulse; honoured only in IDLE.
REQ-006 stop  input  1  one-cycle request to end an active burst early.
REQ-007 burst_len  input  16  samples per burst, captured on start; 0 means continuous until stop.
REQ-008 cfg_seed  input  192  six concatenated 32-bit URNG seeds, captured on start.
REQ-009 core_rst_n  output  1  active-low reset to the noise core.
REQ-010 urng_seed  output  192  registered seeds driven to the noise core.
REQ-011 core_sample  input  16  noise core output, one new sample every cycle; no stall capability.
REQ-012 m_valid / m_ready / m_data  output / input / output  1 / 1 / 16  downstream stream handshake.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a burst fully completes.
REQ-015 drop_cnt  output  16  saturating count of samples lost to FIFO full; cleared on start.

Function
REQ-016 FSM states: IDLE, SEED, WARMUP, STREAM, DRAIN, DONE; encoding is free.
REQ-017 IDLE: start=1 captures burst_len and cfg_seed into urng_seed, clears drop_cnt and the sample counter, and moves to SEED.
REQ-018 SEED lasts exactly 2 cycles with core_rst_n=0, then the FSM moves to WARMUP with core_rst_n=1.
REQ-019 WARMUP lasts exactly WARMUP cycles; core_sample is ignored; then STREAM.
REQ-020 STREAM: every cycle generates one sample; it is pushed into the FIFO unless the FIFO is full, in which case it is dropped and drop_cnt increments, saturating at 0xFFFF.
REQ-021 Full FIFO with a pop in the same cycle (m_valid and m_ready) is not full for push purposes; the push succeeds.
REQ-022 Generated-sample counter counts pushes and drops together; STREAM exits to DRAIN on the cycle the count reaches burst_len (burst_len != 0), or on the cycle after stop=1.
REQ-023 stop and the final count arriving together: one transition to DRAIN and no extra sample.
REQ-024 stop outside STREAM is ignored; start outside IDLE is ignored.
REQ-025 DRAIN: no pushes; wait until the FIFO is empty, then DONE.
REQ-026 DONE: done=1 for one cycle, then IDLE; core_rst_n stays 1 and the core keeps running.
REQ-027 m_valid = FIFO not empty; m_data = FIFO head, stable while m_valid=1 and m_ready=0; pop only on m_valid and m_ready.
REQ-028 FIFO ordering is strictly first-in first-out; pointers wrap modulo FIFO_DEPTH.
REQ-029 Latency: with start sampled at edge T, core_rst_n=0 for edges T+1..T+2; WARMUP covers T+3..T+2+WARMUP; first push occurs at edge T+3+WARMUP; m_valid rises after that edge.

Reset
REQ-030 rst=1 forces immediately: state IDLE, core_rst_n=0, urng_seed=0, FIFO empty, m_valid=0, m_data=0, busy=0, done=0, drop_cnt=0, counters=0.
REQ-031 After rst deasserts, core_rst_n stays 0 until the first SEED state completes.
REQ-032 rst asserted mid-burst discards all FIFO contents without producing a done pulse.

Verification
REQ-033 burst_len=5, m_ready=1, WARMUP=20, start at T -> m_valid first high after edge T+23; exactly 5 samples equal to core_sample at edges T+23..T+27; done one cycle later; drop_cnt=0.
REQ-034 burst_len=10, m_ready=0 throughout STREAM -> 4 samples held in FIFO, drop_cnt=6; DRAIN holds until m_ready=1 pops all 4, then done.
REQ-035 burst_len=0, m_ready=1, stop pulsed 8 cycles into STREAM -> 8 or 9 samples per REQ-022 timing, then DRAIN, done; no further pushes.
REQ-036 FIFO full with m_ready=1 in the same cycle -> push accepted, drop_cnt unchanged; order preserved across pointer wrap.
REQ-037 start pulsed during WARMUP and again during STREAM -> ignored, and captured burst_len and seeds unchanged.
REQ-038 rst pulsed in STREAM with 3 samples queued -> all outputs take REQ-030 values asynchronously; no done; a new start runs a clean burst.
